xgmii_xconnect: RTL and testbench

- Parametrised N-port XGMII cross-connect: every output (TX) port independently forwards the 64b/8c stream of one selectable input (RX) port.
- Source changes and link loss are applied only at frame boundaries, so no truncated frames are emitted; an aborted frame is closed with an error word.
- Sits between the PHY XGMII RX/TX buses and replaces fixed port-pair wiring; per-output frame/abort counters available.

---
 rtl/xgmii_pkg.sv | 11 +
 rtl/xgmii_frame_tracker.sv | 29 ++
 rtl/xgmii_xconnect.sv | 138 +++++++++++++
 tb/tb_xgmii_xconnect.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: shared XGMII control characters, idle/error words and output FSM state
package xgmii_pkg;
  localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
  localparam logic [63:0] XGMII_ERR_D  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]  CH_START     = 8'hFB;
  localparam logic [7:0]  CH_TERM      = 8'hFD;
  localparam logic [7:0]  CH_ERR       = 8'hFE;
  localparam logic [7:0]  CH_IDLE      = 8'h07;
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DRAIN} state_e;
endpackage

// File: rtl/xgmii_frame_tracker.sv
// xgmii_frame_tracker: per-input start/terminate detection and in-frame tracking
module xgmii_frame_tracker
  import xgmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic        start,
  output logic        term,
  output logic        boundary,
  output logic        in_frame_q
);
  logic       start0, start4, in_frame_d;
  logic [7:0] hit;
  always_comb begin
    start0 = rxc[0] && rxd[7:0] == CH_START;
    start4 = rxc[4] && rxd[39:32] == CH_START;
    for (int i = 0; i < 8; i++) hit[i] = rxc[i] && rxd[i*8+:8] == CH_TERM;
    start = start0 || start4;
    term = |hit;
    // a word carrying both only leaves us in-frame when the new frame starts after the old one ends
    in_frame_d = (start && term) ? (start4 && |hit[3:0]) : start ? 1'b1 : term ? 1'b0 : in_frame_q;
    boundary = !in_frame_q && !start;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) in_frame_q <= 1'b0;
    else in_frame_q <= in_frame_d;
endmodule

// File: rtl/xgmii_xconnect.sv
// xgmii_xconnect: N-port XGMII cross-connect switching sources only at frame boundaries
// XCONN_STATS_EN enables per-output frame/abort counters; otherwise they read as zero.
module xgmii_xconnect
  import xgmii_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int SELW  = 3,
  parameter int CNTW  = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NPORT*64-1:0]   xgmii_rxd,
  input  logic [NPORT*8-1:0]    xgmii_rxc,
  input  logic [NPORT-1:0]      link_up,
  input  logic [NPORT*SELW-1:0] sel,
  output logic [NPORT*64-1:0]   xgmii_txd,
  output logic [NPORT*8-1:0]    xgmii_txc,
  output logic [NPORT*SELW-1:0] sel_active,
  output logic [NPORT*CNTW-1:0] frame_cnt,
  output logic [NPORT*CNTW-1:0] abort_cnt
);
  localparam int NSRC = 2**SELW;
  localparam logic [SELW-1:0] NP = SELW'(NPORT);
  // source tables padded to every select code so disabled codes read as link-down, never boundary
  logic [63:0]     rxd_a [NSRC];
  logic [7:0]      rxc_a [NSRC];
  logic [NSRC-1:0] start_a, term_a, bnd_a, infr_a, link_a;
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    if (i < NPORT) begin : g_trk
      assign rxd_a[i]  = xgmii_rxd[i*64+:64];
      assign rxc_a[i]  = xgmii_rxc[i*8+:8];
      assign link_a[i] = link_up[i];
      xgmii_frame_tracker u_trk (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .rxd        (rxd_a[i]),
        .rxc        (rxc_a[i]),
        .start      (start_a[i]),
        .term       (term_a[i]),
        .boundary   (bnd_a[i]),
        .in_frame_q (infr_a[i])
      );
    end else begin : g_nul
      assign rxd_a[i]   = XGMII_IDLE_D;
      assign rxc_a[i]   = XGMII_IDLE_C;
      assign link_a[i]  = 1'b0;
      assign start_a[i] = 1'b0;
      assign term_a[i]  = 1'b0;
      assign bnd_a[i]   = 1'b0;
      assign infr_a[i]  = 1'b0;
    end
  end
`ifndef XCONN_STATS_EN
  logic unused_term;
  assign unused_term = |term_a;
`endif
  for (genvar o = 0; o < NPORT; o++) begin : g_out
    state_e          state_q, state_d;
    logic [SELW-1:0] sel_o, sel_active_q, sel_active_d;
    logic [63:0]     txd_q, txd_d;
    logic [7:0]      txc_q, txc_d;
    logic            go_new, fwd, err;
    assign sel_o  = sel[o*SELW+:SELW];
    assign go_new = sel_o < NP && link_a[sel_o] && bnd_a[sel_o];
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        state_q      <= ST_IDLE;
        sel_active_q <= '1;
        txd_q        <= XGMII_IDLE_D;
        txc_q        <= XGMII_IDLE_C;
      end else begin
        state_q      <= state_d;
        sel_active_q <= sel_active_d;
        txd_q        <= txd_d;
        txc_q        <= txc_d;
      end
    always_comb begin
      state_d = state_q;
      sel_active_d = sel_active_q;
      case (state_q)
        ST_IDLE:
          if (go_new) begin
            state_d = ST_FWD;
            sel_active_d = sel_o;
          end
        ST_FWD:
          if (!link_a[sel_active_q]) begin
            if (infr_a[sel_active_q] || start_a[sel_active_q]) state_d = ST_DRAIN;
            else begin
              state_d = ST_IDLE;
              sel_active_d = '1;
            end
          end else if (sel_o != sel_active_q && bnd_a[sel_active_q]) begin
            if (go_new) sel_active_d = sel_o;
            else begin
              state_d = ST_IDLE;
              sel_active_d = '1;
            end
          end
        ST_DRAIN: begin
          state_d = ST_IDLE;
          sel_active_d = '1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    always_comb begin
      fwd = state_q == ST_FWD && link_a[sel_active_q] && !(sel_o != sel_active_q && bnd_a[sel_active_q]);
      err = state_q == ST_DRAIN ||
            (state_q == ST_FWD && !link_a[sel_active_q] && (infr_a[sel_active_q] || start_a[sel_active_q]));
      txd_d = fwd ? rxd_a[sel_active_q] : err ? XGMII_ERR_D : XGMII_IDLE_D;
      txc_d = fwd ? rxc_a[sel_active_q] : XGMII_IDLE_C;
    end
    assign xgmii_txd[o*64+:64]        = txd_q;
    assign xgmii_txc[o*8+:8]          = txc_q;
    assign sel_active[o*SELW+:SELW]   = sel_active_q;
`ifdef XCONN_STATS_EN
    logic [CNTW-1:0] frame_cnt_q, frame_cnt_d, abort_cnt_q, abort_cnt_d;
    always_comb begin
      frame_cnt_d = frame_cnt_q + CNTW'(fwd && term_a[sel_active_q]);
      abort_cnt_d = abort_cnt_q + CNTW'(state_q == ST_DRAIN);
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
        frame_cnt_q <= '0;
        abort_cnt_q <= '0;
      end else begin
        frame_cnt_q <= frame_cnt_d;
        abort_cnt_q <= abort_cnt_d;
      end
    assign frame_cnt[o*CNTW+:CNTW] = frame_cnt_q;
    assign abort_cnt[o*CNTW+:CNTW] = abort_cnt_q;
`else
    assign frame_cnt[o*CNTW+:CNTW] = '0;
    assign abort_cnt[o*CNTW+:CNTW] = '0;
`endif
  end
endmodule

// File: tb/tb_xgmii_xconnect.sv
// tb_xgmii_xconnect: random XGMII frames per port checked cycle-by-cycle against a behavioural model
module tb_xgmii_xconnect;
  import xgmii_pkg::*;
  localparam int NP = 4, SW = 3, CW = 32;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [NP*64-1:0] rxd, txd;
  logic [NP*8-1:0]  rxc, txc;
  logic [NP-1:0]    link_up;
  logic [NP*SW-1:0] sel, sel_active;
  logic [NP*CW-1:0] frame_cnt, abort_cnt;
  int total = 0, bad = 0;
  logic [63:0] rd [NP];
  logic [7:0]  rc [NP];
  bit busy [NP];
  int rem [NP], gap [NP];
  int mode [NP], act [NP];
  bit inf [NP], mb [NP];
  logic [CW-1:0] fc [NP], ac [NP];
  logic [63:0] ed [NP];
  logic [7:0]  ec [NP];

  always #5 sys_clk = ~sys_clk;

  xgmii_xconnect #(.NPORT(NP), .SELW(SW), .CNTW(CW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .xgmii_rxd(rxd), .xgmii_rxc(rxc),
    .link_up(link_up), .sel(sel), .xgmii_txd(txd), .xgmii_txc(txc),
    .sel_active(sel_active), .frame_cnt(frame_cnt), .abort_cnt(abort_cnt));

  function automatic bit f_start(input logic [63:0] d, input logic [7:0] c);
    return (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
  endfunction
  function automatic bit f_term(input logic [63:0] d, input logic [7:0] c, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) if (c[i] && d[i*8+:8] == 8'hFD) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit ok(input int n);
    if (n >= NP) return 1'b0;
    return link_up[n] && mb[n];
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      mode[o] = 0; act[o] = 7; inf[o] = 1'b0; fc[o] = '0; ac[o] = '0;
      ed[o] = 64'h0707070707070707; ec[o] = 8'hFF;
      busy[o] = 1'b0; gap[o] = $urandom_range(0, 2); rem[o] = 0;
    end
  endtask

  task automatic gen(input int s, output logic [63:0] d, output logic [7:0] c);
    int k;
    d = 64'h0707070707070707; c = 8'hFF;
    if (!busy[s]) begin
      if (gap[s] > 0) gap[s]--;
      else begin
        busy[s] = 1'b1; rem[s] = $urandom_range(1, 6);
        if ($urandom_range(0, 1) == 1) begin
          d[63:8] = {$urandom, $urandom}; d[7:0] = 8'hFB; c = 8'h01;
        end else begin
          d[63:40] = $urandom; d[39:32] = 8'hFB; c = 8'h1F;
        end
      end
    end else if (rem[s] > 0) begin
      rem[s]--; d = {$urandom, $urandom}; c = 8'h00;
    end else begin
      k = $urandom_range(0, 7);
      for (int i = 0; i < k; i++) begin d[i*8+:8] = 8'($urandom); c[i] = 1'b0; end
      d[k*8+:8] = 8'hFD;
      if (k < 4 && $urandom_range(0, 3) == 0) begin
        d[39:32] = 8'hFB; d[63:40] = $urandom; c[7:5] = 3'b000; rem[s] = $urandom_range(1, 6);
      end else begin
        busy[s] = 1'b0; gap[s] = $urandom_range(0, 2);
      end
    end
  endtask

  task automatic model();
    bit st [NP], tm [NP];
    int sv, s;
    for (int i = 0; i < NP; i++) begin
      st[i] = f_start(rd[i], rc[i]); tm[i] = f_term(rd[i], rc[i], 0, 7); mb[i] = !inf[i] && !st[i];
    end
    for (int o = 0; o < NP; o++) begin
      sv = int'(sel[o*SW+:SW]); s = act[o];
      ed[o] = 64'h0707070707070707; ec[o] = 8'hFF;
      if (mode[o] == 0) begin
        if (ok(sv)) begin mode[o] = 1; act[o] = sv; end
      end else if (mode[o] == 1) begin
        if (!link_up[s]) begin
          if (inf[s] || st[s]) begin mode[o] = 2; ed[o] = 64'hFEFEFEFEFEFEFEFE; end
          else begin mode[o] = 0; act[o] = 7; end
        end else if (sv != s && mb[s]) begin
          if (ok(sv)) act[o] = sv;
          else begin mode[o] = 0; act[o] = 7; end
        end else begin
          ed[o] = rd[s]; ec[o] = rc[s];
          if (tm[s]) fc[o]++;
        end
      end else begin
        ed[o] = 64'hFEFEFEFEFEFEFEFE; ac[o]++; mode[o] = 0; act[o] = 7;
      end
    end
    for (int i = 0; i < NP; i++)
      if (st[i] && tm[i]) inf[i] = rc[i][4] && rd[i][39:32] == 8'hFB && f_term(rd[i], rc[i], 0, 3);
      else if (st[i]) inf[i] = 1'b1;
      else if (tm[i]) inf[i] = 1'b0;
  endtask

  task automatic check();
    logic [CW-1:0] xf, xa;
    for (int o = 0; o < NP; o++) begin
`ifdef XCONN_STATS_EN
      xf = fc[o]; xa = ac[o];
`else
      xf = '0; xa = '0;
`endif
      total++;
      assert ({txd[o*64+:64], txc[o*8+:8]} === {ed[o], ec[o]}) else begin
        bad++; $error("FAIL tx%0d got %h/%h want %h/%h", o, txd[o*64+:64], txc[o*8+:8], ed[o], ec[o]);
      end
      total++;
      assert (sel_active[o*SW+:SW] === SW'(act[o])) else begin
        bad++; $error("FAIL sel_active%0d got %0d want %0d", o, sel_active[o*SW+:SW], act[o]);
      end
      total++;
      assert (frame_cnt[o*CW+:CW] === xf) else begin
        bad++; $error("FAIL frame_cnt%0d got %0d want %0d", o, frame_cnt[o*CW+:CW], xf);
      end
      total++;
      assert (abort_cnt[o*CW+:CW] === xa) else begin
        bad++; $error("FAIL abort_cnt%0d got %0d want %0d", o, abort_cnt[o*CW+:CW], xa);
      end
    end
  endtask

  task automatic drive();
    for (int s = 0; s < NP; s++) begin
      gen(s, rd[s], rc[s]);
      rxd[s*64+:64] = rd[s]; rxc[s*8+:8] = rc[s];
    end
  endtask

  task automatic run(input int n, input int sel_rate, input int link_rate, input bit mc);
    int p;
    for (int c = 0; c < n; c++) begin
      if (sel_rate > 0 && $urandom_range(0, sel_rate - 1) == 0) begin
        p = $urandom_range(0, NP - 1); sel[p*SW+:SW] = SW'($urandom_range(0, 7));
      end
      if (link_rate > 0)
        for (int q = 0; q < NP; q++)
          if (link_up[q]) begin
            if ($urandom_range(0, link_rate - 1) == 0) link_up[q] = 1'b0;
          end else if ($urandom_range(0, 7) == 0) link_up[q] = 1'b1;
      drive();
      model();
      @(posedge sys_clk); #1;
      check();
      if (mc && mode[2] == 1 && mode[3] == 1 && act[2] == 0 && act[3] == 0) begin
        total++;
        assert ({txd[2*64+:64], txc[2*8+:8]} === {txd[3*64+:64], txc[3*8+:8]}) else begin
          bad++; $error("FAIL multicast tx2 %h/%h tx3 %h/%h", txd[2*64+:64], txc[2*8+:8], txd[3*64+:64], txc[3*8+:8]);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    for (int s = 0; s < NP; s++) begin
      rd[s] = 64'h0707070707070707; rc[s] = 8'hFF;
      rxd[s*64+:64] = rd[s]; rxc[s*8+:8] = rc[s];
    end
  endtask

  initial begin
    link_up = '1;
    sel = {3'd3, 3'd2, 3'd1, 3'd0};
    idle_inputs();
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1 check();
    sys_rst_n = 1'b1;
    sel = {3'd2, 3'd3, 3'd0, 3'd1};
    run(300, 0, 0, 1'b0);
    run(600, 25, 0, 1'b0);
    sel = {3'd0, 3'd0, 3'd2, 3'd0};
    run(600, 0, 0, 1'b1);
    sel[0*SW+:SW] = 3'd7;
    run(60, 0, 0, 1'b0);
    sel[0*SW+:SW] = 3'd0;
    run(100, 0, 0, 1'b0);
    run(3000, 20, 40, 1'b0);
    sys_rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1 check();
    repeat (3) begin
      @(posedge sys_clk); #1;
      check();
    end
    sys_rst_n = 1'b1;
    link_up = '1;
    sel = {3'd2, 3'd3, 3'd0, 3'd1};
    run(500, 30, 60, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
